// File: rtl/discrete_node_mac_sequencer_if.sv
// Sample-strobe / operand / node-output bundle for the discrete node MAC sequencer.
// master drives the strobe and inputs, slave returns the node state and status.
interface discrete_node_mac_sequencer_if;
    logic               audio_clk_en;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;
    logic signed [15:0] v_control;
    logic signed [16:0] node_state;
    logic               busy;
    logic               done;
    logic               overrun;

    modport master (
        output audio_clk_en, in_a, in_b,
        input  v_control, node_state, busy, done, overrun
    );

    modport slave (
        input  audio_clk_en, in_a, in_b,
        output v_control, node_state, busy, done, overrun
    );
endinterface

// File: rtl/discrete_node_mac_sequencer.sv
// One RC node update x[n+1] = sum(coef_i * operand_i) through a single shared multiplier.
// Optional DISCRETE_MAC_SAT_EN: clamp the committed state instead of wrapping to 17 bits.
module discrete_node_mac_sequencer #(
    parameter int unsigned COEF_STATE  = 4091,
    parameter int unsigned COEF_A      = 2169,
    parameter int unsigned COEF_VCC    = 2646,
    parameter int unsigned COEF_B      = 3615,
    parameter int unsigned SHIFT_STATE = 12,
    parameter int unsigned SHIFT_A     = 1,
    parameter int unsigned SHIFT_VCC   = 2,
    parameter int unsigned SHIFT_B     = 0,
    parameter int unsigned ACC_SHIFT   = 24,
    parameter int unsigned VCC_Q12     = 20480,
    parameter int unsigned OUT_COEF    = 3276
) (
    input  logic                               clk,
    input  logic                               I_RSTn,
    discrete_node_mac_sequencer_if.slave       bus
);

    localparam logic [12:0]        L_CS  = 13'(COEF_STATE);
    localparam logic [12:0]        L_CA  = 13'(COEF_A);
    localparam logic [12:0]        L_CV  = 13'(COEF_VCC);
    localparam logic [12:0]        L_CB  = 13'(COEF_B);
    localparam logic [12:0]        L_OC  = 13'(OUT_COEF);
    localparam logic [5:0]         L_SS  = 6'(SHIFT_STATE);
    localparam logic [5:0]         L_SA  = 6'(SHIFT_A);
    localparam logic [5:0]         L_SV  = 6'(SHIFT_VCC);
    localparam logic [5:0]         L_SB  = 6'(SHIFT_B);
    localparam logic signed [16:0] L_VCC = 17'(VCC_Q12);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic signed [16:0] r_op_s;
    logic signed [16:0] r_op_a;
    logic signed [16:0] r_op_b;
    logic signed [47:0] r_acc;
    logic signed [16:0] r_node_state;
    logic signed [15:0] r_v_control;
    logic               r_done;
    logic               r_overrun;

    logic signed [19:0] w_ext_a;
    logic signed [19:0] w_ext_b;
    logic signed [19:0] w_x5_a;
    logic signed [19:0] w_x5_b;
    logic signed [16:0] w_den_a;
    logic signed [16:0] w_den_b;

    logic signed [16:0] w_mul_op;
    logic [12:0]        w_mul_coef;
    logic [5:0]         w_shift;
    logic               w_busy;
    logic signed [30:0] w_prod;
    logic signed [47:0] w_term;
    logic signed [16:0] w_new_state;
    logic signed [30:0] w_vprod;

    // Normalized input to Q12 volts: x * 5 / 4, floored.
    assign w_ext_a = 20'(bus.in_a);
    assign w_ext_b = 20'(bus.in_b);
    assign w_x5_a  = w_ext_a * 20'sd5;
    assign w_x5_b  = w_ext_b * 20'sd5;
    assign w_den_a = 17'(w_x5_a >>> 2);
    assign w_den_b = 17'(w_x5_b >>> 2);

    // The one shared multiplier: signed operand times zero-extended coefficient.
    assign w_prod = w_mul_op * $signed({1'b0, w_mul_coef});
    assign w_term = 48'(w_prod) <<< w_shift;

`ifdef DISCRETE_MAC_SAT_EN
    logic signed [47:0] w_acc_sh;
    assign w_acc_sh    = r_acc >>> ACC_SHIFT;
    assign w_new_state = (w_acc_sh > 48'sd65535)  ? 17'sd65535 :
                         (w_acc_sh < -48'sd65536) ? $signed(17'h10000) :
                         17'(w_acc_sh);
`else
    assign w_new_state = 17'(r_acc >>> ACC_SHIFT);
`endif

    assign w_vprod = w_new_state * $signed({1'b0, L_OC});

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!I_RSTn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Fixed walk through the four terms; strobes outside IDLE never redirect it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.audio_clk_en) w_next = S_MAC0;
            S_MAC0:   w_next = S_MAC1;
            S_MAC1:   w_next = S_MAC2;
            S_MAC2:   w_next = S_MAC3;
            S_MAC3:   w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-state multiplier operand, coefficient and product alignment.
    always_comb begin
        w_mul_op   = r_op_s;
        w_mul_coef = L_CS;
        w_shift    = L_SS;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_MAC1: begin
                w_mul_op   = r_op_a;
                w_mul_coef = L_CA;
                w_shift    = L_SA;
            end
            S_MAC2: begin
                w_mul_op   = L_VCC;
                w_mul_coef = L_CV;
                w_shift    = L_SV;
            end
            S_MAC3: begin
                w_mul_op   = r_op_b;
                w_mul_coef = L_CB;
                w_shift    = L_SB;
            end
            default: ;
        endcase
    end

    // Operand capture, accumulation, commit and sticky overrun.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            r_op_s       <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_acc        <= '0;
            r_node_state <= '0;
            r_v_control  <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.audio_clk_en) begin
                        r_op_s <= r_node_state;
                        r_op_a <= w_den_a;
                        r_op_b <= w_den_b;
                        r_acc  <= '0;
                    end
                end
                S_MAC0, S_MAC1, S_MAC2, S_MAC3: r_acc <= r_acc + w_term;
                S_COMMIT: begin
                    r_node_state <= w_new_state;
                    r_v_control  <= 16'(w_vprod >>> 12);
                    r_done       <= 1'b1;
                end
                default: ;
            endcase
            if (bus.audio_clk_en && r_state != S_IDLE) r_overrun <= 1'b1;
        end
    end

    assign bus.node_state = r_node_state;
    assign bus.v_control  = r_v_control;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;

endmodule
